// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: request, adder and response signals of the shared adder arbiter
//   en, req_*          : requester side (issue enable, valid/ready, operands, carry in)
//   add_*              : registered operands out to the pipelined adder, {cout,sum} back
//   rsp_*, done_cnt*   : per-port result pulses, shared result bus, completion counters
//   master             : environment view (requesters plus adder)
//   slave              : arbiter view
interface adder_share_arbiter_if #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
);
    logic             en;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic             req_cin0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic             req_cin1;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;
    logic [1:0]       rsp_valid;
    logic [WIDTH:0]   rsp_sum;
    logic [CNT_W-1:0] done_cnt0;
    logic [CNT_W-1:0] done_cnt1;
    modport master (
        output en, req_valid, req_a0, req_b0, req_cin0, req_a1, req_b1, req_cin1, add_s, add_cout,
        input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, done_cnt0, done_cnt1
    );
    modport slave (
        input  en, req_valid, req_a0, req_b0, req_cin0, req_a1, req_b1, req_cin1, add_s, add_cout,
        output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, done_cnt0, done_cnt1
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one pipelined adder between two requesters
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave view of adder_share_arbiter_if (requests, adder operands/results,
//              per-port response pulses, shared {cout,sum} bus, completion counters)
module adder_share_arbiter #(
    parameter int WIDTH   = 128,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 16
) (
    input logic                 clk,
    input logic                 rst,
    adder_share_arbiter_if.slave bus
);
    logic           ptr;
    logic [1:0]     grant;
    logic [LATENCY:0] tag_v;
    logic [LATENCY:0] tag_id;
    always_comb begin
        grant = 2'b00;
        if (bus.en && !rst)
            grant = (bus.req_valid == 2'b11) ? (ptr ? 2'b10 : 2'b01) : bus.req_valid;
    end
    assign bus.req_ready = grant;
    // Stage 0 is loaded together with add_*, so stage LATENCY lines up with add_s/add_cout.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr           <= 1'b0;
            tag_v         <= '0;
            tag_id        <= '0;
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.add_cin   <= 1'b0;
            bus.rsp_valid <= 2'b00;
            bus.rsp_sum   <= '0;
            bus.done_cnt0 <= '0;
            bus.done_cnt1 <= '0;
        end else begin
            if (|grant) begin
                ptr         <= grant[0];
                bus.add_a   <= grant[1] ? bus.req_a1 : bus.req_a0;
                bus.add_b   <= grant[1] ? bus.req_b1 : bus.req_b0;
                bus.add_cin <= grant[1] ? bus.req_cin1 : bus.req_cin0;
            end
            tag_v         <= {tag_v[LATENCY-1:0], |grant};
            tag_id        <= {tag_id[LATENCY-1:0], grant[1]};
            bus.rsp_valid <= tag_v[LATENCY] ? (tag_id[LATENCY] ? 2'b10 : 2'b01) : 2'b00;
            if (tag_v[LATENCY]) begin
                bus.rsp_sum <= {bus.add_cout, bus.add_s};
                if (tag_id[LATENCY])
                    bus.done_cnt1 <= bus.done_cnt1 + CNT_W'(1);
                else
                    bus.done_cnt0 <= bus.done_cnt0 + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed and random checks of adder_share_arbiter against a transaction model
module tb_adder_share_arbiter;
    localparam int W = 128;
    localparam int L = 4;
    typedef struct {
        int         due;
        bit         port;
        logic [W:0] sum;
    } rsp_t;
    logic clk = 0;
    logic rst;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit prio = 0;
    logic [15:0] m_cnt0 = 0;
    logic [15:0] m_cnt1 = 0;
    rsp_t q[$];
    logic [W:0] pipe [L];
    always #5 clk = ~clk;
    adder_share_arbiter_if #(.WIDTH(W), .CNT_W(16)) bus ();
    adder_share_arbiter #(.WIDTH(W), .LATENCY(L), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always_ff @(posedge clk) begin
        pipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + (W + 1)'(bus.add_cin);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.add_s    = pipe[L-1][W-1:0];
    assign bus.add_cout = pipe[L-1][W];
    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask
    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic cycle(input bit e, input bit r, input logic [1:0] v,
                         input logic [W-1:0] a0, input logic [W-1:0] b0, input bit c0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input bit c1);
        logic [1:0] g;
        logic [1:0] rv;
        logic [W:0] rs;
        int hit;
        bus.en = e; rst = r; bus.req_valid = v;
        bus.req_a0 = a0; bus.req_b0 = b0; bus.req_cin0 = c0;
        bus.req_a1 = a1; bus.req_b1 = b1; bus.req_cin1 = c1;
        #1;
        if (!e || r) g = 2'b00;
        else if (v == 2'b11) g = prio ? 2'b10 : 2'b01;
        else g = v;
        chk("req_ready", (W + 1)'(bus.req_ready), (W + 1)'(g));
        rv = 2'b00; rs = '0; hit = -1;
        foreach (q[i]) if (q[i].due == cyc) hit = i;
        if (hit >= 0) begin
            rv = q[hit].port ? 2'b10 : 2'b01;
            rs = q[hit].sum;
            if (q[hit].port) m_cnt1++; else m_cnt0++;
            q.delete(hit);
        end
        chk("rsp_valid", (W + 1)'(bus.rsp_valid), (W + 1)'(rv));
        if (rv != 2'b00) chk("rsp_sum", bus.rsp_sum, rs);
        chk("done_cnt0", (W + 1)'(bus.done_cnt0), (W + 1)'(m_cnt0));
        chk("done_cnt1", (W + 1)'(bus.done_cnt1), (W + 1)'(m_cnt1));
        if (r) begin
            q.delete(); prio = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else if (g != 2'b00) begin
            q.push_back('{cyc + L + 2, g[1],
                g[1] ? {1'b0, a1} + {1'b0, b1} + (W + 1)'(c1) : {1'b0, a0} + {1'b0, b0} + (W + 1)'(c0)});
            prio = g[0];
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 2'b00, '0, '0, 0, '0, '0, 0);
    endtask
    task automatic both_rand(input bit e);
        cycle(e, 0, 2'b11, rnd(), rnd(), 1'($urandom), rnd(), rnd(), 1'($urandom));
    endtask
    initial begin
        rst = 1; bus.en = 0; bus.req_valid = 0;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_cin0 = 0;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_cin1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset add_a", (W + 1)'(bus.add_a), '0);
        chk("reset add_b", (W + 1)'(bus.add_b), '0);
        chk("reset add_cin", (W + 1)'(bus.add_cin), '0);
        chk("reset rsp_sum", bus.rsp_sum, '0);
        cycle(0, 0, 2'b11, rnd(), rnd(), 0, rnd(), rnd(), 0);
        cycle(1, 0, 2'b01, W'(5), W'(7), 0, '0, '0, 0);
        idle(7);
        cycle(1, 0, 2'b10, '0, '0, 0, '1, W'(1), 0);
        idle(7);
        cycle(1, 1, 2'b00, '0, '0, 0, '0, '0, 0);
        for (int i = 0; i < 8; i++) both_rand(1);
        idle(8);
        for (int i = 0; i < 10; i++) cycle(1, 0, 2'b01, W'(i), W'(i), 0, '0, '0, 0);
        idle(8);
        for (int i = 0; i < 3; i++) both_rand(1);
        for (int i = 0; i < 10; i++) both_rand(0);
        cycle(1, 0, 2'b01, rnd(), rnd(), 1, '0, '0, 0);
        cycle(1, 0, 2'b10, '0, '0, 0, rnd(), rnd(), 1);
        idle(2);
        cycle(1, 1, 2'b00, '0, '0, 0, '0, '0, 0);
        idle(8);
        both_rand(1);
        both_rand(1);
        idle(8);
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 8) != 0, ($urandom % 60) == 0, 2'($urandom),
                  rnd(), rnd(), 1'($urandom), rnd(), rnd(), 1'($urandom));
        idle(8);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
